dbus_responder: RTL and testbench

//   Responder end of the data-bus handshake that the memory stage initiates for loads/stores.

---
 rtl/dbus_responder_pkg.sv | 28 ++
 rtl/dbus_ram.sv | 28 ++
 rtl/dbus_responder.sv | 138 +++++++++++++
 tb/tb_dbus_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types: access size encoding and request/response bundles.
package common;

  typedef enum logic [2:0] {
    MSIZE_1B = 3'd0,
    MSIZE_2B = 3'd1,
    MSIZE_4B = 3'd2,
    MSIZE_8B = 3'd3
  } msize_t;

  localparam int unsigned DBUS_WORD_BYTES = 8;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
    logic        err;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_ram.sv
// Word RAM behind the responder: byte-enable synchronous write, asynchronous read, no reset.
module dbus_ram
  import common::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [7:0]    strobe,
  input  logic [AW-1:0] index,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DBUS_WORD_BYTES; i++) begin
        if (strobe[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dbus_responder.sv
// Single-outstanding data-bus responder with fixed access latency, backed by dbus_ram.
module dbus_responder
  import common::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] CNT_INIT = (LATENCY >= 2) ? 32'(LATENCY - 2) : '0;
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  dbus_req_t   lat, cur;
  logic        load, enter_resp;
  logic        misaligned, out_of_range, bad_size, err;
  logic [63:0] offset, rdata, data_q;
  logic        err_q, we;
  dbus_resp_t  resp;

  // While idle the live inputs are the request (needed when LATENCY==1 commits
  // on the accepting edge); afterwards only the latch is consulted.
  always_comb begin
    cur = lat;
    if (state == ST_IDLE) begin
      cur.valid  = req_valid;
      cur.addr   = req_addr;
      cur.size   = msize_t'(req_size);
      cur.strobe = req_strobe;
      cur.data   = req_data;
    end
  end

  always_comb begin
    offset       = cur.addr - BASE_ADDR;
    bad_size     = cur.size > MSIZE_8B;
    out_of_range = (cur.addr < BASE_ADDR) || (offset >= SPAN);
    misaligned   = 1'b0;
    case (cur.size)
      MSIZE_2B: misaligned = cur.addr[0];
      MSIZE_4B: misaligned = |cur.addr[1:0];
      MSIZE_8B: misaligned = |cur.addr[2:0];
      default:  misaligned = 1'b0;
    endcase
    err = bad_size || misaligned || out_of_range;
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    load       = 1'b0;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cur.valid) begin
          load = 1'b1;
          if (LATENCY == 1) begin
            state_nx   = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nx   = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      lat    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) lat <= cur;
      if (enter_resp) begin
        err_q  <= err;
        data_q <= (err || cur.strobe != '0) ? '0 : rdata;
      end
    end
  end

  // Reset gates the commit so a write pending in WAIT is dropped.
  assign we = reset && enter_resp && !err && (cur.strobe != '0);

  dbus_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk    (clk),
    .we     (we),
    .strobe (cur.strobe),
    .index  (offset[AW+2:3]),
    .wdata  (cur.data),
    .rdata  (rdata)
  );

  always_comb begin
    resp         = '0;
    resp.addr_ok = (state == ST_RESP);
    resp.data_ok = (state == ST_RESP);
    resp.data    = (state == ST_RESP) ? data_q : '0;
    resp.err     = (state == ST_RESP) && err_q;
  end

  assign resp_addr_ok = resp.addr_ok;
  assign resp_data_ok = resp.data_ok;
  assign resp_data    = resp.data;
  assign resp_err     = resp.err;

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized self-checking bench for dbus_responder against a word-map reference model.
module tb_dbus_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset, reset4;
  logic        req_valid, req_valid4;
  logic [63:0] req_addr, req_data;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic        aok, dok, rerr, aok4, dok4, rerr4;
  logic [63:0] rdat, rdat4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] mdl [int];

  always #5 clk = ~clk;

  dbus_responder #(.LATENCY(2), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(aok), .resp_data_ok(dok), .resp_data(rdat), .resp_err(rerr)
  );

  dbus_responder #(.LATENCY(4), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .reset(reset4), .req_valid(req_valid4), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(aok4), .resp_data_ok(dok4), .resp_data(rdat4), .resp_err(rerr4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [63:0] a, input logic [2:0] s);
    if (s > 3'd3) return 1'b1;
    if ((a % (64'd1 << s)) != 64'd0) return 1'b1;
    if (a < BASE || a >= BASE + 64'(DEPTH) * 64'd8) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int key_of(input bit sel, input logic [63:0] a);
    return (sel ? 4096 : 0) + int'(((a - BASE) / 64'd8) % 64'(DEPTH));
  endfunction

  task automatic wait_resp(input bit sel, output int cyc, output logic [63:0] d, output logic e);
    cyc = 0;
    d   = '0;
    e   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sel ? dok4 : dok) begin
        cyc = i;
        d   = sel ? rdat4 : rdat;
        e   = sel ? rerr4 : rerr;
        chk("addr_ok_with_data_ok", 64'(sel ? aok4 : aok), 64'd1);
        break;
      end
    end
  endtask

  task automatic txn(input bit sel, input logic [63:0] a, input logic [2:0] s,
                     input logic [7:0] st, input logic [63:0] d, input string tag);
    logic [63:0] exp_d, got_d, w;
    bit          exp_e;
    logic        got_e;
    int          cyc, key;
    exp_e = ref_err(a, s);
    key   = key_of(sel, a);
    exp_d = '0;
    if (!exp_e) begin
      w = mdl.exists(key) ? mdl[key] : 64'd0;
      if (st == 8'h00) exp_d = w;
      else begin
        for (int b = 0; b < 8; b++) if (st[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[key] = w;
      end
    end
    req_addr = a; req_size = s; req_strobe = st; req_data = d;
    if (sel) req_valid4 = 1'b1; else req_valid = 1'b1;
    wait_resp(sel, cyc, got_d, got_e);
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), sel ? 64'd4 : 64'd2);
    chk({tag, "_err"}, 64'(got_e), 64'(exp_e));
    chk({tag, "_data"}, got_d, exp_d);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(sel ? dok4 : dok), 64'd0);
  endtask

  initial begin
    logic [63:0] a, d, got_d;
    logic [2:0]  s;
    logic [7:0]  st;
    logic        got_e;
    int          cyc, r, pulses, first, last, gap_bad;

    reset = 1'b0; reset4 = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0;
    req_addr = '0; req_size = '0; req_strobe = '0; req_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1; reset4 = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 16; w++)
      txn(0, BASE + 64'(w) * 8, 3'd3, 8'hFF, {$urandom, $urandom}, "init");
    txn(0, BASE + 64'(DEPTH - 1) * 8, 3'd3, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, "init_top");
    txn(1, BASE + 64'h10, 3'd3, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, "init4");

    // Reset held with a pending request: outputs stay low, accept follows release.
    reset = 1'b0;
    req_addr = BASE + 64'h18; req_size = 3'd3; req_strobe = 8'h00; req_data = '0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outs", {rdat[63:3], rdat[2:0] | {aok, dok, rerr}}, 64'd0);
    end
    reset = 1'b1;
    wait_resp(0, cyc, got_d, got_e);
    req_valid = 1'b0;
    chk("rst_release_lat", 64'(cyc), 64'd2);
    chk("rst_release_data", got_d, mdl[key_of(0, BASE + 64'h18)]);
    @(negedge clk);

    txn(0, BASE + 64'h10, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, "wr_full");
    txn(0, BASE + 64'h10, 3'd3, 8'h00, 64'd0, "rd_full");
    txn(0, BASE + 64'h10, 3'd3, 8'h0C, 64'h0000_0000_AABB_0000, "wr_part");
    chk("part_model", mdl[key_of(0, BASE + 64'h10)], 64'h1122_3344_AABB_7788);
    txn(0, BASE + 64'h10, 3'd3, 8'h00, 64'd0, "rd_part");

    txn(0, BASE + 64'h13, 3'd2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "err_mis");
    txn(0, 64'h7FFF_FFF8, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "err_lo");
    txn(0, BASE + 64'(DEPTH) * 8, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "err_hi");
    txn(0, BASE + 64'h10, 3'd3, 8'h00, 64'd0, "rd_after_mis");
    txn(0, BASE + 64'(DEPTH - 1) * 8, 3'd3, 8'h00, 64'd0, "rd_after_lo");
    txn(0, BASE, 3'd3, 8'h00, 64'd0, "rd_after_hi");

    // Held valid: one response per LATENCY+1 cycles.
    req_addr = BASE + 64'h18; req_size = 3'd3; req_strobe = 8'h00;
    req_valid = 1'b1;
    pulses = 0; first = 0; last = 0; gap_bad = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (dok) begin
        if (pulses == 0) first = i;
        else if (i - last != 3) gap_bad++;
        last = i;
        pulses++;
        chk("held_data", rdat, mdl[key_of(0, BASE + 64'h18)]);
      end
    end
    req_valid = 1'b0;
    chk("held_count", 64'(pulses), 64'd3);
    chk("held_first", 64'(first), 64'd2);
    chk("held_gap", 64'(gap_bad), 64'd0);
    @(negedge clk);

    // LATENCY=4: reset in the second WAIT cycle drops the write and the response.
    req_addr = BASE + 64'h10; req_size = 3'd3; req_strobe = 8'hFF;
    req_data = 64'h0123_4567_89AB_CDEF;
    req_valid4 = 1'b1;
    pulses = 0;
    @(negedge clk);
    if (dok4) pulses++;
    @(negedge clk);
    if (dok4) pulses++;
    reset4 = 1'b0; req_valid4 = 1'b0;
    @(negedge clk);
    reset4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dok4) pulses++;
    end
    chk("midrst_no_resp", 64'(pulses), 64'd0);
    txn(1, BASE + 64'h10, 3'd3, 8'h00, 64'd0, "midrst_rd");

    for (int n = 0; n < 60; n++) begin
      s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0 && s <= 3'd3) a = a & ~((64'd1 << s) - 64'd1);
      r = int'($urandom_range(0, 9));
      if (r == 0) a = BASE - 64'($urandom_range(1, 64));
      else if (r == 1) a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 63));
      st = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      d  = {$urandom, $urandom};
      txn(0, a, s, st, d, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
